// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-requester RAM arbiter: requester
// indices used for ownership tracking and the strobe value meaning "read".
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        REQ_M0   = 2'd0,
        REQ_M1   = 2'd1,
        REQ_NONE = 2'd2
    } req_idx_t;

    localparam logic [3:0] WSTRB_READ = 4'b0000;

    // Map a one-bit winner select onto the requester index.
    function automatic req_idx_t idx_of(input logic sel);
        return sel ? REQ_M1 : REQ_M0;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin grant logic. A caller-supplied hold (locked owner)
// overrides the round-robin choice; otherwise a lone requester wins and a
// tie goes to whichever side was not granted most recently.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       hold_valid,
    input  logic       hold_sel,
    output logic [1:0] gnt
);

    // 1 means m1 was granted last, so m0 is preferred on the next tie.
    logic last_reg;

    // Combinational grant selection; nothing is granted while in reset.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (hold_valid) begin
                gnt[hold_sel] = 1'b1;
            end else begin
                case (req)
                    2'b01:   gnt = 2'b01;
                    2'b10:   gnt = 2'b10;
                    2'b11:   gnt = last_reg ? 2'b01 : 2'b10;
                    default: gnt = 2'b00;
                endcase
            end
        end
    end

    // Remember who was granted last on every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg <= 1'b1;
        end else if (|gnt) begin
            last_reg <= gnt[1];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one word RAM between a CPU data port (m0) and a loader/DMA port
// (m1). Round-robin arbitration with bounded locked bursts, a winner-driven
// address/data mux and a one-cycle registered read return per requester.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 15,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_wenable,
    input  logic [31:0]       ram_rdata
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

    logic [1:0]        req_v;
    logic [1:0]        lock_v;
    logic [ADDR_W-1:0] addr_v  [2];
    logic [31:0]       wdata_v [2];
    logic [3:0]        wstrb_v [2];

    assign req_v      = {m1_req, m0_req};
    assign lock_v     = {m1_lock, m0_lock};
    assign addr_v[0]  = m0_addr;
    assign addr_v[1]  = m1_addr;
    assign wdata_v[0] = m0_wdata;
    assign wdata_v[1] = m1_wdata;
    assign wstrb_v[0] = m0_wstrb;
    assign wstrb_v[1] = m1_wstrb;

    req_idx_t          owner_reg, owner_next;
    logic [7:0]        burst_cnt_reg, burst_cnt_next;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic              owner_sel;
    logic              hold_valid;
    logic [1:0]        gnt;
    logic              any_gnt;
    logic              win_sel;
    req_idx_t          win_idx;

    // The locked owner keeps the RAM while it still requests, unless the
    // other side is waiting and the burst has reached its limit.
    assign owner_sel  = (owner_reg == REQ_M1);
    assign hold_valid = (owner_reg != REQ_NONE) && req_v[owner_sel] &&
                        (!req_v[~owner_sel] || (burst_cnt_reg < MAX_CNT));

    rr_arb2 u_rr (
        .clk        (clk),
        .rst        (rst),
        .req        (req_v),
        .hold_valid (hold_valid),
        .hold_sel   (owner_sel),
        .gnt        (gnt)
    );

    assign any_gnt = |gnt;
    assign win_sel = gnt[1];
    assign win_idx = idx_of(win_sel);
    assign m0_gnt  = gnt[0];
    assign m1_gnt  = gnt[1];

    // Address holds its last granted value when idle; writes only on grant.
    assign ram_addr    = any_gnt ? addr_v[win_sel] : ram_addr_reg;
    assign ram_wdata   = wdata_v[win_sel];
    assign ram_wenable = any_gnt ? wstrb_v[win_sel] : 4'b0000;

    // Ownership/burst bookkeeping: a locked grant extends or starts a burst,
    // anything else releases ownership.
    always_comb begin
        owner_next     = REQ_NONE;
        burst_cnt_next = 8'd0;
        if (any_gnt && lock_v[win_sel]) begin
            owner_next = win_idx;
            if (owner_reg == win_idx) begin
                burst_cnt_next = (burst_cnt_reg >= MAX_CNT) ? MAX_CNT
                                                            : burst_cnt_reg + 8'd1;
            end else begin
                burst_cnt_next = 8'd1;
            end
        end
    end

    // Ownership, burst count and held address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_reg     <= REQ_NONE;
            burst_cnt_reg <= 8'd0;
            ram_addr_reg  <= '0;
        end else begin
            owner_reg     <= owner_next;
            burst_cnt_reg <= burst_cnt_next;
            if (any_gnt) begin
                ram_addr_reg <= addr_v[win_sel];
            end
        end
    end

    logic [1:0]  rvalid_v;
    logic [31:0] rdata_v [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ret
            logic        rvalid_reg;
            logic [31:0] rdata_reg;

            // Capture the RAM word one cycle after a granted read.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= 32'h0;
                end else begin
                    rvalid_reg <= gnt[gi] && (wstrb_v[gi] == WSTRB_READ);
                    if (gnt[gi] && (wstrb_v[gi] == WSTRB_READ)) begin
                        rdata_reg <= ram_rdata;
                    end
                end
            end

            assign rvalid_v[gi] = rvalid_reg;
            assign rdata_v[gi]  = rdata_reg;
        end
    endgenerate

    // A return still in flight when reset arrives is never presented.
    assign m0_rvalid = rvalid_v[0] & ~rst;
    assign m1_rvalid = rvalid_v[1] & ~rst;
    assign m0_rdata  = rdata_v[0];
    assign m1_rdata  = rdata_v[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios followed by randomized
// two-requester traffic, checked every cycle against a behavioural model.
module tb_ram_arbiter;

    localparam int ADDR_W    = 15;
    localparam int MAX_BURST = 8;
    localparam int WORDS     = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [1:0]        req_v;
    logic [1:0]        lock_v;
    logic [ADDR_W-1:0] addr_v  [2];
    logic [31:0]       wdata_v [2];
    logic [3:0]        wstrb_v [2];

    logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0]       m0_rdata, m1_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata, ram_rdata;
    logic [3:0]        ram_wenable;

    ram_arbiter #(.ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
        .clk         (clk),
        .rst         (rst),
        .m0_req      (req_v[0]),
        .m0_lock     (lock_v[0]),
        .m0_addr     (addr_v[0]),
        .m0_wdata    (wdata_v[0]),
        .m0_wstrb    (wstrb_v[0]),
        .m0_gnt      (m0_gnt),
        .m0_rvalid   (m0_rvalid),
        .m0_rdata    (m0_rdata),
        .m1_req      (req_v[1]),
        .m1_lock     (lock_v[1]),
        .m1_addr     (addr_v[1]),
        .m1_wdata    (wdata_v[1]),
        .m1_wstrb    (wstrb_v[1]),
        .m1_gnt      (m1_gnt),
        .m1_rvalid   (m1_rvalid),
        .m1_rdata    (m1_rdata),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_wenable (ram_wenable),
        .ram_rdata   (ram_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'hDEADBEEF;
        if (i == 64) return 32'hAAAAAAAA;
        return 32'(i) * 32'h9E3779B9;
    endfunction

    // RAM macro stand-in: byte-enabled synchronous write, combinational read.
    logic [31:0] ram_mem [WORDS];
    logic        preload;
    assign ram_rdata = ram_mem[ram_addr[ADDR_W-1:2]];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < WORDS; i++) ram_mem[i] <= init_word(i);
        end else begin
            for (int b = 0; b < 4; b++)
                if (ram_wenable[b])
                    ram_mem[ram_addr[ADDR_W-1:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    // Reference model state.
    logic [31:0]       ref_mem [WORDS];
    int                m_owner, m_cnt, m_last, m_win, obs_win;
    logic              m_rvalid [2];
    logic [31:0]       m_rdata  [2];
    logic [ADDR_W-1:0] m_last_addr;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner     = -1;
        m_cnt       = 0;
        m_last      = 1;
        m_rvalid[0] = 1'b0;
        m_rvalid[1] = 1'b0;
        m_rdata[0]  = 32'h0;
        m_rdata[1]  = 32'h0;
        m_last_addr = '0;
    endtask

    // Winner chosen from the arbitration rules in priority order.
    function automatic int model_pick();
        int other;
        if (rst) return -1;
        if (m_owner >= 0) begin
            other = 1 - m_owner;
            if (req_v[m_owner] && (!req_v[other] || m_cnt < MAX_BURST)) return m_owner;
        end
        if (req_v[0] && !req_v[1]) return 0;
        if (req_v[1] && !req_v[0]) return 1;
        if (req_v[0] && req_v[1]) return (m_last == 0) ? 1 : 0;
        return -1;
    endfunction

    // Inputs are already applied; check at mid-cycle, advance the model at the edge.
    task automatic do_cycle();
        logic [31:0] w;
        int          idx;
        #4;
        m_win = model_pick();
        check_eq("m0_gnt", 32'(m0_gnt), 32'(m_win == 0));
        check_eq("m1_gnt", 32'(m1_gnt), 32'(m_win == 1));
        check_eq("ram_wenable", 32'(ram_wenable), (m_win >= 0) ? 32'(wstrb_v[m_win]) : 32'h0);
        check_eq("ram_addr", 32'(ram_addr), (m_win >= 0) ? 32'(addr_v[m_win]) : 32'(m_last_addr));
        if (m_win >= 0) check_eq("ram_wdata", ram_wdata, wdata_v[m_win]);
        check_eq("m0_rvalid", 32'(m0_rvalid), 32'(m_rvalid[0] && !rst));
        check_eq("m1_rvalid", 32'(m1_rvalid), 32'(m_rvalid[1] && !rst));
        check_eq("m0_rdata", m0_rdata, m_rdata[0]);
        check_eq("m1_rdata", m1_rdata, m_rdata[1]);
        obs_win = m1_gnt ? 1 : (m0_gnt ? 0 : -1);
        if (m_win >= 0)
            $display("txn t=%0t m%0d %s addr=%h wdata=%h strb=%h lock=%0d", $time, m_win,
                     (wstrb_v[m_win] == 4'h0) ? "rd" : "wr", addr_v[m_win],
                     wdata_v[m_win], wstrb_v[m_win], lock_v[m_win]);
        if (rst) begin
            model_reset();
        end else begin
            m_rvalid[0] = 1'b0;
            m_rvalid[1] = 1'b0;
            if (m_win >= 0) begin
                idx = int'(addr_v[m_win][ADDR_W-1:2]);
                if (wstrb_v[m_win] == 4'h0) begin
                    m_rvalid[m_win] = 1'b1;
                    m_rdata[m_win]  = ref_mem[idx];
                end else begin
                    w = ref_mem[idx];
                    for (int b = 0; b < 4; b++)
                        if (wstrb_v[m_win][b]) w[8*b +: 8] = wdata_v[m_win][8*b +: 8];
                    ref_mem[idx] = w;
                end
                m_last      = m_win;
                m_last_addr = addr_v[m_win];
                if (lock_v[m_win]) begin
                    m_cnt   = (m_owner == m_win) ? ((m_cnt < MAX_BURST) ? m_cnt + 1 : MAX_BURST) : 1;
                    m_owner = m_win;
                end else begin
                    m_owner = -1;
                    m_cnt   = 0;
                end
            end else begin
                m_owner = -1;
                m_cnt   = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic r, input logic l, input int a,
                           input logic [31:0] d, input logic [3:0] s);
        req_v[i]   = r;
        lock_v[i]  = l;
        addr_v[i]  = ADDR_W'(a);
        wdata_v[i] = d;
        wstrb_v[i] = s;
    endtask

    task automatic idle_all();
        set_req(0, 1'b0, 1'b0, 0, 32'h0, 4'h0);
        set_req(1, 1'b0, 1'b0, 0, 32'h0, 4'h0);
    endtask

    task automatic new_req(input int i);
        logic [3:0] s;
        s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        set_req(i, 1'b1, 1'($urandom_range(0, 1)), 4 * $urandom_range(0, 15),
                $urandom, s);
    endtask

    task automatic reset_cycle();
        idle_all();
        rst = 1'b1;
        do_cycle();
        rst = 1'b0;
    endtask

    initial begin
        int n1;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        idle_all();
        rst     = 1'b1;
        preload = 1'b1;
        @(posedge clk);
        #1;
        preload = 1'b0;
        model_reset();

        // Reset state, then lone m0 read of 0x0040.
        reset_cycle();
        set_req(0, 1'b1, 1'b0, 'h40, 32'h0, 4'h0);
        do_cycle();
        check_eq("rd_alone_gnt", 32'(obs_win), 32'(0));
        idle_all();
        do_cycle();
        check_eq("rd_alone_rvalid", 32'(m0_rvalid), 32'h0);
        check_eq("rd_alone_rdata", m0_rdata, 32'hDEADBEEF);
        do_cycle();
        do_cycle();

        // Continuous contention without lock alternates from m0.
        reset_cycle();
        set_req(0, 1'b1, 1'b0, 'h80, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b0, 'h84, 32'h11223344, 4'hF);
        for (int k = 0; k < 8; k++) begin
            do_cycle();
            check_eq("alternate", 32'(obs_win), 32'(k % 2));
        end

        // Locked m1 burst yields to pending m0 after MAX_BURST grants.
        reset_cycle();
        set_req(1, 1'b1, 1'b1, 'h200, 32'hCAFE0000, 4'hF);
        do_cycle();
        set_req(0, 1'b1, 1'b0, 'h300, 32'h0, 4'h0);
        n1 = (obs_win == 1) ? 1 : 0;
        for (int k = 0; k < 12; k++) begin
            do_cycle();
            if (obs_win != 1) break;
            n1++;
        end
        check_eq("burst_len", 32'(n1), 32'(MAX_BURST));
        check_eq("yield_to_m0", 32'(obs_win), 32'(0));
        idle_all();
        do_cycle();

        // Partial write by m1 then read by m0 of the same word.
        set_req(1, 1'b1, 1'b0, 'h100, 32'h12345678, 4'h3);
        do_cycle();
        idle_all();
        set_req(0, 1'b1, 1'b0, 'h100, 32'h0, 4'h0);
        do_cycle();
        idle_all();
        do_cycle();
        check_eq("rmw_rdata", m0_rdata, 32'hAAAA5678);

        // Reset in the middle of an m0 locked read burst.
        set_req(0, 1'b1, 1'b1, 'h40, 32'h0, 4'h0);
        do_cycle();
        do_cycle();
        rst = 1'b1;
        do_cycle();
        rst = 1'b0;
        check_eq("rst_cancel_rvalid", 32'(m0_rvalid), 32'h0);
        check_eq("rst_rdata", m0_rdata, 32'h0);
        set_req(0, 1'b1, 1'b0, 'h44, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b0, 'h48, 32'h0, 4'h0);
        do_cycle();
        check_eq("post_rst_m0", 32'(obs_win), 32'(0));
        idle_all();
        do_cycle();

        // Randomized traffic with occasional withdrawals and resets.
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!req_v[i]) begin
                    if ($urandom_range(0, 9) < 6) new_req(i);
                end else if ($urandom_range(0, 19) == 0) begin
                    req_v[i] = 1'b0;
                end
            end
            do_cycle();
            for (int i = 0; i < 2; i++) begin
                if (m_win == i) begin
                    if ($urandom_range(0, 9) < 7) new_req(i);
                    else req_v[i] = 1'b0;
                end
            end
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one synchronous-write / combinational-read word RAM (same RAM macro as the system RAM) between two bus requesters.
  - Port m0: CPU data port.
  - Port m1: loader/DMA engine filling RAM before or alongside CPU execution.
- Round-robin arbitration, optional locked bursts with a bounded length, one-cycle registered read return.
- Sits between the requesters and the RAM instance; the address decode that selects RAM (addr bit 31) stays upstream.

Parameters:
- ADDR_W, 15, word-RAM byte-address width forwarded to the RAM.
- MAX_BURST, 8, max consecutive locked grants to one requester while the other is requesting (range 1..255).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  requester 0 access request
- m0_lock  in  1  requester 0 asks to keep ownership after this access
- m0_addr  in  ADDR_W  byte address
- m0_wdata  in  32  write data
- m0_wstrb  in  4  byte write enables; 0 = read
- m0_gnt  out  1  access accepted this cycle
- m0_rvalid  out  1  read data valid
- m0_rdata  out  32  read data
- m1_req, m1_lock, m1_addr, m1_wdata, m1_wstrb, m1_gnt, m1_rvalid, m1_rdata  same as m0_* for requester 1
- ram_addr  out  ADDR_W  to RAM addr
- ram_wdata  out  32  to RAM wdata
- ram_wenable  out  4  to RAM byte write enables
- ram_rdata  in  32  from RAM, combinational read of ram_addr

Behaviour:
- Reset (rst high at edge):
  - rvalid both 0; rdata both 0x0; burst counter 0; owner = none; rr pointer = m0 preferred.
  - While rst is high: gnt both 0, ram_wenable 0.
- Grant is combinational within the cycle; at most one gnt high per cycle.
- Requester protocol: hold req/addr/wdata/wstrb/lock stable until it sees gnt. A deasserted req before gnt is allowed (request withdrawn).
- Selection, in priority order each cycle:
  1. Locked owner: if an owner exists, its req=1, and the burst may continue (other req=0, or burst_cnt < MAX_BURST), the owner wins.
  2. Otherwise, if only one req is high, that requester wins.
  3. If both are high, the requester not granted most recently wins.
- Granted cycle:
  - ram_addr/ram_wdata mux from the winner.
  - ram_wenable = winner wstrb.
  - No grant: ram_addr holds last value; ram_wenable = 0.
- Read return: when the granted wstrb == 0, register ram_rdata into winner rdata and assert winner rvalid for exactly the next cycle. Writes produce no rvalid. rdata holds its value when rvalid is 0.
- Back-to-back: one access per cycle sustained; rvalid of access N coincides with gnt of N+1.
- Ownership / burst state, at each edge:
  - On grant with lock=1: owner <= winner; burst_cnt <= burst_cnt+1 if same owner, else 1.
  - On grant with lock=0, or no grant: owner <= none; burst_cnt <= 0.
  - Last-granted pointer updates on every grant.
- Forced yield:
  - When burst_cnt == MAX_BURST and the other requester is pending, the other wins next cycle.
  - The yielding requester's lock is then treated as a fresh request.
  - If the other is idle, the owner continues and burst_cnt saturates at MAX_BURST.
- Owner drops req while lock recorded: ownership released that cycle; normal rules apply.
- Same address written by one requester and read by the other in consecutive cycles: the read sees the new data.
- rst mid-burst: ownership cleared; a pending rvalid is cancelled (not emitted).

Decomposition:
- Shared package holds the requester index constants (REQ_M0=0, REQ_M1=1, REQ_NONE) and the read-strobe constant WSTRB_READ=4'b0000.
- One natural sub-module, rr_arb2: 2-way round-robin grant logic with last-grant pointer. The top adds the lock/burst counter, datapath mux and read-return registers.

Test Plan:
- m0 read of addr 0x0040 alone (RAM word 0xDEADBEEF) -> m0_gnt same cycle, m0_rvalid next cycle, m0_rdata=0xDEADBEEF, m1 outputs quiet.
- Both req continuously, no lock, reset pointer -> grants alternate m0,m1,m0,m1 for 8 cycles; ram_wenable follows each winner's wstrb.
- m1 locked writes (wstrb=0xF) with m0 pending, MAX_BURST=8 -> exactly 8 consecutive m1 grants, then m0 granted on the 9th cycle.
- m1 writes 0x12345678 to 0x0100 with wstrb=0x3, m0 reads 0x0100 next cycle (prior word 0xAAAAAAAA) -> m0_rdata=0xAAAA5678.
- rst asserted during an m0 locked burst with a read just granted -> no rvalid next cycle; all outputs at reset values; first post-reset contention goes to m0.
- m0 read granted then both idle -> m0_rvalid high exactly one cycle, m0_rdata holds value afterwards, ram_wenable stays 0.
